sorted_floats_serializer: RTL and testbench

Downstream stage of the three-float FSM sorter. Captures each sorted triple (with its error flag) into a small triple buffer when the sorter pulses its valid output, then streams the three FLEN-bit values one per transfer over a valid/ready interface, in ascending slot order. It decouples the sorter's one-cycle result pulse from a consumer that may stall.

---
 rtl/sorted_floats_serializer.sv | 195 +++++++++++++++++++
 tb/tb_sorted_floats_serializer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sorted_floats_serializer.sv
// ---------------------------------------------------------------------------
// sorted_floats_serializer
//
// Downstream stage of the three-float FSM sorter. Each sorted triple and its
// error flag are captured into a circular buffer of DEPTH slots when the
// sorter pulses in_valid. The three FLEN-bit values are then streamed one per
// transfer over a valid/ready interface, smallest first. This decouples the
// sorter's one-cycle result pulse from a consumer that may stall.
//
// Parameters:
//   FLEN   float width (normally 64, matching the sorter configuration)
//   DEPTH  triple slots buffered, 1..8
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   in_valid     sorter result pulse
//   in_data      sorted triple, in_data[0] is the smallest
//   in_err       sorter error flag for this triple
//   in_ready     at least one slot free (registered count only)
//   out_valid    out_data holds a valid element
//   out_ready    consumer accepts the element
//   out_data     current element
//   out_idx      element position within its triple, 0..2
//   out_last     out_idx == 2
//   out_err      error flag of the triple being streamed
//   overflow     sticky: a triple arrived while the buffer was full
//
// Build option:
//   SORTED_SER_DROP_ERR_EN  when defined, error triples are discarded on
//                           arrival (not counted as overflow) and out_err
//                           is tied to 0.
// ---------------------------------------------------------------------------
module sorted_floats_serializer #(
  parameter int FLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [0:2][FLEN-1:0] in_data,
  input  logic                 in_err,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FLEN-1:0]      out_data,
  output logic [1:0]           out_idx,
  output logic                 out_last,
  output logic                 out_err,
  output logic                 overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [CW-1:0]          count_q, count_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic                   overflow_q, overflow_d;
  logic [0:2][FLEN-1:0]   data_q [DEPTH];
  logic [0:2][FLEN-1:0]   data_d [DEPTH];
  logic [DEPTH-1:0]       err_q, err_d;

  logic full;
  logic accept_kind;  // triple is of a kind this build buffers at all
  logic push;
  logic xfer;
  logic pop;

  // -------------------------------------------------------------------------
  // Datapath next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    data_d     = data_q;
    err_d      = err_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    idx_d      = idx_q;
    count_d    = count_q;
    overflow_d = overflow_q;

`ifdef SORTED_SER_DROP_ERR_EN
    accept_kind = !in_err;
`else
    accept_kind = 1'b1;
`endif

    // Fullness uses the count at the start of the cycle: a same-cycle pop
    // never rescues an arriving triple, keeping in_ready off out_ready.
    full = (count_q == CW'(DEPTH));
    push = in_valid && accept_kind && !full;
    xfer = out_valid && out_ready;
    pop  = xfer && (idx_q == 2'd2);

    if (in_valid && accept_kind && full) begin
      overflow_d = 1'b1;
    end

    if (push) begin
      data_d[wr_ptr_q] = in_data;
      err_d[wr_ptr_q]  = in_err;
      wr_ptr_d         = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end

    if (xfer) begin
      if (idx_q == 2'd2) begin
        idx_d    = 2'd0;
        rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (push) state_d = SEND;
      SEND: if (pop && (count_d == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM outputs: all derived from registered state, so nothing bypasses the
  // buffer and the element holds while the consumer stalls.
  // -------------------------------------------------------------------------
  always_comb begin
    out_valid = (state_q == SEND);
    out_data  = '0;
    out_idx   = 2'd0;
    out_last  = 1'b0;
    out_err   = 1'b0;
    if (out_valid) begin
      out_data = data_q[rd_ptr_q][idx_q];
      out_idx  = idx_q;
      out_last = (idx_q == 2'd2);
`ifndef SORTED_SER_DROP_ERR_EN
      out_err  = err_q[rd_ptr_q];
`endif
    end
    in_ready = (count_q < CW'(DEPTH));
    overflow = overflow_q;
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      err_q      <= '0;
      // NOTE: the buffer storage is reset too, so nothing stale from before
      // reset can ever be presented on out_data; with DEPTH <= 8 triples
      // this stays in flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_sorted_floats_serializer.sv
// ---------------------------------------------------------------------------
// tb_sorted_floats_serializer
//
// Scoreboard bench for sorted_floats_serializer (FLEN = 64, DEPTH = 2).
// The stimulus pushes the expected element stream of every accepted triple
// into a queue; an independent monitor pops and compares on each transfer
// and checks that a stalled element holds still. Directed cycle-level checks
// cover latency, in_ready, overflow, back-to-back pushes and async reset.
// ---------------------------------------------------------------------------
module tb_sorted_floats_serializer;

  localparam int FLEN  = 64;
  localparam int DEPTH = 2;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  idx;
    logic        last;
    logic        err;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic [0:2][FLEN-1:0] in_data;
  logic                 in_err;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [FLEN-1:0]      out_data;
  logic [1:0]           out_idx;
  logic                 out_last;
  logic                 out_err;
  logic                 overflow;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  sorted_floats_serializer #(.FLEN(FLEN), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_err    (in_err),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_err   (out_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold in_valid for one edge; when the triple should be accepted, queue
  // its three elements for the monitor.
  task automatic push(input logic [0:2][63:0] t, input logic e, input bit acc);
    exp_t x;
    in_valid = 1'b1;
    in_data  = t;
    in_err   = e;
    if (acc) begin
      for (int i = 0; i < 3; i++) begin
        x.data = t[i];
        x.idx  = 2'(i);
        x.last = (i == 2);
        x.err  = e;
        sb.push_back(x);
      end
    end
    cyc(1);
    in_valid = 1'b0;
    in_err   = 1'b0;
    in_data  = '0;
  endtask

  // ---------------------------------------------------------------------
  // Monitor: compares each transfer against the scoreboard and checks that
  // a stalled element is unchanged one cycle later.
  // ---------------------------------------------------------------------
  logic        stall_prev = 1'b0;
  logic [63:0] prev_data;
  logic [1:0]  prev_idx;
  logic        prev_err;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid) begin
        check("hold_data", out_data, prev_data);
        check("hold_idx", 64'(out_idx), 64'(prev_idx));
        check("hold_err", 64'(out_err), 64'(prev_err));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_xfer", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check("sb_data", out_data, e.data);
          check("sb_idx", 64'(out_idx), 64'(e.idx));
          check("sb_last", 64'(out_last), 64'(e.last));
          check("sb_err", 64'(out_err), 64'(e.err));
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = out_idx;
      prev_err   = out_err;
    end
  end

  localparam logic [63:0] F1 = 64'h3FF0_0000_0000_0000;  // 1.0
  localparam logic [63:0] F2 = 64'h4000_0000_0000_0000;  // 2.0
  localparam logic [63:0] F3 = 64'h4008_0000_0000_0000;  // 3.0
  localparam logic [63:0] F4 = 64'h4010_0000_0000_0000;  // 4.0
  localparam logic [63:0] F5 = 64'h4014_0000_0000_0000;  // 5.0
  localparam logic [63:0] F6 = 64'h4018_0000_0000_0000;  // 6.0
  localparam logic [63:0] F7 = 64'h401C_0000_0000_0000;  // 7.0
  localparam logic [63:0] F8 = 64'h4020_0000_0000_0000;  // 8.0
  localparam logic [63:0] F9 = 64'h4022_0000_0000_0000;  // 9.0

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_err    = 1'b0;
    out_ready = 1'b0;
    cyc(1);

    // ---- reset values ----
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_idx", 64'(out_idx), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    cyc(1);

    // ---- basic stream, consumer always ready ----
    out_ready = 1'b1;
    push({F1, F2, F3}, 1'b0, 1'b1);
    check("lat_n1_valid", 64'(out_valid), 64'd1);
    check("lat_n1_data", out_data, F1);
    check("lat_n1_idx", 64'(out_idx), 64'd0);
    check("lat_n1_last", 64'(out_last), 64'd0);
    cyc(1);
    check("lat_n2_data", out_data, F2);
    check("lat_n2_idx", 64'(out_idx), 64'd1);
    check("lat_n2_last", 64'(out_last), 64'd0);
    cyc(1);
    check("lat_n3_data", out_data, F3);
    check("lat_n3_idx", 64'(out_idx), 64'd2);
    check("lat_n3_last", 64'(out_last), 64'd1);
    cyc(1);
    check("lat_n4_valid", 64'(out_valid), 64'd0);

    // ---- consumer stall for 4 cycles ----
    out_ready = 1'b0;
    push({F1, F2, F3}, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("stall_data", out_data, F1);
      check("stall_idx", 64'(out_idx), 64'd0);
      if (i < 3) cyc(1);
    end
    out_ready = 1'b1;
    cyc(1);
    check("stall_rel_e1", out_data, F2);
    cyc(1);
    check("stall_rel_e2", out_data, F3);
    check("stall_rel_last", 64'(out_last), 64'd1);
    cyc(1);
    check("stall_rel_done", 64'(out_valid), 64'd0);

    // ---- error triple ----
`ifdef SORTED_SER_DROP_ERR_EN
    push({F4, F5, F6}, 1'b1, 1'b0);
    check("errdrop_valid", 64'(out_valid), 64'd0);
    check("errdrop_overflow", 64'(overflow), 64'd0);
    check("errdrop_in_ready", 64'(in_ready), 64'd1);
    cyc(3);
    check("errdrop_valid_late", 64'(out_valid), 64'd0);
`else
    push({F4, F5, F6}, 1'b1, 1'b1);
    check("err_out_err", 64'(out_err), 64'd1);
    check("err_valid", 64'(out_valid), 64'd1);
    cyc(3);
    check("err_done", 64'(out_valid), 64'd0);
    check("err_overflow", 64'(overflow), 64'd0);
`endif

    // ---- fill to DEPTH, then overflow ----
    out_ready = 1'b0;
    push({F1, F2, F3}, 1'b0, 1'b1);      // A
    check("ovf_in_ready_a", 64'(in_ready), 64'd1);
    push({F4, F5, F6}, 1'b0, 1'b1);      // B
    check("ovf_in_ready_b", 64'(in_ready), 64'd0);
    check("ovf_before_c", 64'(overflow), 64'd0);
    push({F7, F8, F9}, 1'b0, 1'b0);      // C, dropped
    check("ovf_after_c", 64'(overflow), 64'd1);
    check("ovf_head_a", out_data, F1);
    out_ready = 1'b1;
    cyc(6);
    check("ovf_drained", 64'(out_valid), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);
    check("ovf_in_ready_back", 64'(in_ready), 64'd1);

    // ---- push in the same cycle as the idx 2 pop: no bubble ----
    push({F1, F3, F5}, 1'b0, 1'b1);      // D
    cyc(2);
    check("b2b_idx2", 64'(out_idx), 64'd2);
    push({F2, F4, F6}, 1'b0, 1'b1);      // E, lands on D's pop edge
    check("b2b_valid", 64'(out_valid), 64'd1);
    check("b2b_data", out_data, F2);
    check("b2b_idx0", 64'(out_idx), 64'd0);
    check("b2b_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
    push({F7, F8, F9}, 1'b0, 1'b1);      // F fills slot two only if count was 1
    check("b2b_count_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    cyc(6);
    check("b2b_drained", 64'(out_valid), 64'd0);

    // ---- asynchronous reset during the idx 1 element ----
    push({F3, F6, F9}, 1'b0, 1'b1);      // G
    cyc(1);
    check("arst_pre_idx", 64'(out_idx), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_data", out_data, 64'd0);
    check("arst_idx", 64'(out_idx), 64'd0);
    check("arst_last", 64'(out_last), 64'd0);
    check("arst_err", 64'(out_err), 64'd0);
    check("arst_overflow", 64'(overflow), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    cyc(1);
    rst = 1'b0;
    cyc(1);
    push({F2, F5, F8}, 1'b0, 1'b1);      // H
    check("post_rst_idx", 64'(out_idx), 64'd0);
    check("post_rst_data", out_data, F2);
    cyc(3);
    check("post_rst_done", 64'(out_valid), 64'd0);

    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
